// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the buffered UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic UART_STOP_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_buffered_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_buffered_tx_if
// Description : Host-side write port and serial status of the buffered UART
//               transmitter. The host drives the master side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_buffered_tx_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                          wr_en;
    logic [DATA_BITS-1:0]          wr_data;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          tx_line;
    logic                          tx_busy;

    modport master (
        output wr_en, wr_data,
        input  full, fifo_count, tx_line, tx_busy
    );

    modport slave (
        input  wr_en, wr_data,
        output full, fifo_count, tx_line, tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with occupancy count. Pushes while full and
//               pops while empty are ignored. Depth must be a power of two so
//               the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic               push,
    input  wire logic [WIDTH-1:0]   push_data,
    input  wire logic               pop,
    output logic      [WIDTH-1:0]   pop_data,
    output logic                    full,
    output logic                    empty,
    output logic      [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_acc, pop_acc;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Qualify requests against the registered flags and advance pointers/count
    always_comb begin
        push_acc = push && !full;
        pop_acc  = pop && !empty;
        wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_acc  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_buffered_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_buffered_tx
// Description : 8N1-style buffered UART transmitter, LSB first, idle-high.
//               Bytes queue in a write FIFO; frames are sent back-to-back by
//               popping the next byte on the final stop-bit cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_buffered_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_BITS    = 8
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    uart_buffered_tx_if.slave bus
);
    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_width(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_tx_state_t             state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0]       shift_q, shift_d;
    logic                       tx_line_q, tx_line_d;
    logic                       tx_busy_q, tx_busy_d;
    logic                       bit_end;

    logic                       fifo_pop;
    logic [DATA_BITS-1:0]       fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.full       = fifo_full;
    assign bus.fifo_count = fifo_count;
    assign bus.tx_line    = tx_line_q;
    assign bus.tx_busy    = tx_busy_q;

    assign bit_end = (baud_q == BAUD_LAST);

    // Frame sequencer: next state, baud/bit counters, shifter and line level
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next frame when a byte is waiting
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the upcoming state so it can be registered
        case (state_d)
            START:   tx_line_d = UART_START_LEVEL;
            DATA:    tx_line_d = shift_d[0];
            default: tx_line_d = UART_STOP_LEVEL;
        endcase
        tx_busy_d = (state_d != IDLE);
    end

    // Sequencer registers; reset forces the line idle immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_line_q <= UART_STOP_LEVEL;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_line_q <= tx_line_d;
            tx_busy_q <= tx_busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_buffered_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_buffered_tx
// Description : Self-checking bench for uart_buffered_tx: segment tables,
//               hand-written corner sequences, randomized traffic against a
//               waveform-queue reference model, and a behavioural receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_buffered_tx;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int DBITS = 8;
    localparam int FRAME = (DBITS + 2) * CPB;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_buffered_tx_if #(.DATA_BITS(DBITS), .FIFO_DEPTH(DEPTH)) bus ();

    uart_buffered_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_BITS    (DBITS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes waiting, plus the per-cycle line levels still to come
    logic [7:0] m_q[$];
    bit         m_wave[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_got[$];
    int         rx_ferr = 0;

    // Per-section statistics
    int cyc, busy_total, first_busy, last_busy;
    bit line_low_seen;

    typedef struct {
        logic       we;
        logic [7:0] d;
        int         n;
        logic       line;
        logic       busy;
        int         cnt;
    } seg_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {25'd0, bus.tx_line, bus.tx_busy, bus.full, bus.fifo_count};
    endfunction

    function automatic logic [31:0] model_vec();
        logic ln, bz, fl;
        ln = (m_wave.size() != 0) ? m_wave[0] : 1'b1;
        bz = (m_wave.size() != 0);
        fl = (m_q.size() == DEPTH);
        return {25'd0, ln, bz, fl, 4'(m_q.size())};
    endfunction

    // One clock edge of the reference model, using pre-edge occupancy
    task automatic model_edge(input logic we, input logic [7:0] d);
        bit do_pop, do_push, dummy;
        logic [7:0] b;
        do_pop  = (m_wave.size() <= 1) && (m_q.size() != 0);
        do_push = we && (m_q.size() < DEPTH);
        if (m_wave.size() != 0) dummy = m_wave.pop_front();
        if (do_pop) begin
            b = m_q.pop_front();
            for (int k = 0; k < CPB; k++) m_wave.push_back(1'b0);
            for (int i = 0; i < DBITS; i++)
                for (int k = 0; k < CPB; k++) m_wave.push_back(b[i]);
            for (int k = 0; k < CPB; k++) m_wave.push_back(1'b1);
        end
        if (do_push) begin
            m_q.push_back(d);
            exp_rx.push_back(d);
        end
    endtask

    task automatic stats_clear();
        cyc = 0; busy_total = 0; first_busy = -1; last_busy = -1; line_low_seen = 1'b0;
    endtask

    // Drive inputs for one cycle, advance model, compare all outputs after the edge
    task automatic cycle(input logic we, input logic [7:0] d);
        bus.wr_en   = we;
        bus.wr_data = d;
        @(posedge clk);
        model_edge(we, d);
        #1;
        chk("cycle_outputs", dut_vec(), model_vec());
        cyc++;
        if (bus.tx_busy) begin
            busy_total++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
        end
        if (!bus.tx_line) line_low_seen = 1'b1;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int k = 0; k < (DEPTH + 2) * FRAME; k++) begin
            cycle(1'b0, 8'h00);
            if (!bus.tx_busy && bus.fifo_count == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_drain_done"}, 32'(done), 32'd1);
        repeat (2) cycle(1'b0, 8'h00);
    endtask

    task automatic check_rx_list(input string name, input logic [7:0] lst[$]);
        chk({name, "_rx_count"}, 32'(rx_got.size()), 32'(lst.size()));
        for (int i = 0; i < lst.size() && i < rx_got.size(); i++)
            chk($sformatf("%s_rx_byte%0d", name, i), 32'(rx_got[i]), 32'(lst[i]));
        chk({name, "_framing_error"}, 32'(rx_ferr), 32'd0);
        rx_got.delete(); exp_rx.delete(); rx_ferr = 0;
    endtask

    // Asynchronous reset applied between edges, held three clocks
    task automatic do_reset(input string name);
        #2 reset_n = 1'b0;
        bus.wr_en = 1'b0;
        #1 chk({name, "_async"}, dut_vec(), 32'h40);
        m_q.delete(); m_wave.delete();
        repeat (3) @(posedge clk);
        #1 chk({name, "_hold"}, dut_vec(), 32'h40);
        reset_n = 1'b1;
        exp_rx.delete(); rx_got.delete(); rx_ferr = 0;
    endtask

    // Behavioural receiver: mid-bit sampling on the falling clock edge
    initial begin : rx_model
        int cnt, j;
        bit active;
        logic [7:0] sh;
        active = 1'b0; cnt = 0; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active = 1'b0;
            end else if (!active) begin
                if (bus.tx_line == 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                end
            end else begin
                cnt++;
                if (cnt % CPB == CPB / 2) begin
                    j = cnt / CPB;
                    if (j == 0) begin
                        if (bus.tx_line != 1'b0) active = 1'b0;
                    end else if (j <= DBITS) begin
                        sh[j-1] = bus.tx_line;
                    end else begin
                        if (bus.tx_line !== 1'b1) rx_ferr++;
                        rx_got.push_back(sh);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        seg_t       t2[12];
        logic [7:0] lst[$];
        logic [7:0] b4d;
        int         push_cyc, pct;

        bus.wr_en = 1'b0; bus.wr_data = 8'h00;
        stats_clear();

        // Reset state, then reset while a frame is on the line
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", dut_vec(), 32'h40);
        reset_n = 1'b1;
        cycle(1'b1, 8'h12);
        cycle(1'b1, 8'h34);
        repeat (30) cycle(1'b0, 8'h00);
        do_reset("reset_mid_activity");

        // Single byte 0x4D against a fixed segment table
        b4d = 8'h4D;
        t2[0]  = '{1'b1, 8'h4D, 1,  1'b1, 1'b0, 1};
        t2[1]  = '{1'b0, 8'h00, CPB, 1'b0, 1'b1, 0};
        for (int i = 0; i < DBITS; i++) t2[2+i] = '{1'b0, 8'h00, CPB, b4d[i], 1'b1, 0};
        t2[10] = '{1'b0, 8'h00, CPB, 1'b1, 1'b1, 0};
        t2[11] = '{1'b0, 8'h00, 4,   1'b1, 1'b0, 0};
        stats_clear();
        cycle(1'b0, 8'h00);
        push_cyc = -1;
        for (int s = 0; s < 12; s++) begin
            for (int k = 0; k < t2[s].n; k++) begin
                cycle(t2[s].we, t2[s].d);
                if (t2[s].we) push_cyc = cyc;
                chk($sformatf("single_seg%0d_cyc%0d", s, k), dut_vec(),
                    {25'd0, t2[s].line, t2[s].busy, 1'b0, 4'(t2[s].cnt)});
            end
        end
        chk("single_busy_len", 32'(busy_total), 32'(FRAME));
        chk("single_busy_start", 32'(first_busy), 32'(push_cyc + 1));
        lst = {8'h4D};
        check_rx_list("single", lst);

        // Back-to-back pushes: frames must abut with no idle cycle
        stats_clear();
        cycle(1'b1, 8'hA5); chk("b2b_count1", 32'(bus.fifo_count), 32'd1);
        cycle(1'b1, 8'h3C); chk("b2b_count2", 32'(bus.fifo_count), 32'd1);
        cycle(1'b1, 8'hFF); chk("b2b_count3", 32'(bus.fifo_count), 32'd2);
        drain("b2b");
        chk("b2b_busy_total", 32'(busy_total), 32'(3 * FRAME));
        chk("b2b_busy_span", 32'(last_busy - first_busy + 1), 32'(3 * FRAME));
        chk("b2b_final_count", 32'(bus.fifo_count), 32'd0);
        lst = {8'hA5, 8'h3C, 8'hFF};
        check_rx_list("b2b", lst);

        // Overflow: nine pushes into a depth-8 FIFO while a frame is in flight
        stats_clear();
        cycle(1'b1, 8'hC3);
        cycle(1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 8'(i));
            if (i == 6) chk("ovf_not_full_at7", 32'(bus.full), 32'd0);
            if (i == 7) chk("ovf_full_at8", 32'(bus.full), 32'd1);
        end
        chk("ovf_count_after9", 32'(bus.fifo_count), 32'(DEPTH));
        chk("ovf_still_full", 32'(bus.full), 32'd1);
        drain("ovf");
        lst = {8'hC3};
        for (int i = 0; i < 8; i++) lst.push_back(8'(i));
        check_rx_list("ovf", lst);

        // Reset at data bit 3 of the first of two queued frames
        stats_clear();
        cycle(1'b1, 8'h55);
        cycle(1'b1, 8'hAA);
        repeat (CPB + 3 * CPB + 5) cycle(1'b0, 8'h00);
        chk("midrst_busy_before", 32'(bus.tx_busy), 32'd1);
        do_reset("midrst");
        stats_clear();
        repeat (2 * FRAME) cycle(1'b0, 8'h00);
        chk("midrst_no_busy", 32'(busy_total), 32'd0);
        chk("midrst_line_stays_high", 32'(line_low_seen), 32'd0);
        chk("midrst_no_rx", 32'(rx_got.size()), 32'd0);
        exp_rx.delete();

        // Loopback with a gap, then a push mid-frame
        stats_clear();
        cycle(1'b1, 8'h4D);
        repeat (5) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h00);
        repeat (40) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hFF);
        drain("loop");
        lst = {8'h4D, 8'h00, 8'hFF};
        check_rx_list("loop", lst);

        // Randomized traffic at several push densities against the model
        stats_clear();
        for (int p = 0; p < 4; p++) begin
            pct = (p == 0) ? 10 : (p == 1) ? 50 : (p == 2) ? 100 : 3;
            for (int k = 0; k < 600; k++)
                cycle(($urandom_range(0, 99) < pct), 8'($urandom));
        end
        drain("random");
        check_rx_list("random", exp_rx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
